mul_tree_sched: RTL and testbench

Request scheduler in front of `mul_tree_bf16`, the shared bf16 multiplier tree.
- Arbitrates up to `NREQ` requesters round-robin and drives the tree's `mul_ins`/`mul_stb`/`mode` inputs.
- Tracks in-flight operations in an ID FIFO and routes each tree result back tagged with its requester ID.
- Serialises mode changes: the tree drains completely before `mode` switches, because per-mode latency differs.

---
 rtl/mul_tree_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_mul_tree_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_tree_sched.sv
// mul_tree_sched: round-robin request scheduler in front of the shared bf16
// multiplier tree. Tracks in-flight requester IDs in a FIFO, tags returning
// tree results with them, and drains the tree before any mode change.
// Optional watchdog: define MUL_TREE_SCHED_WDOG_EN.
module mul_tree_sched #(
    parameter int DW     = 16,
    parameter int NREQ   = 4,
    parameter int IW     = 128,
    parameter int DEPTH  = 16,
    parameter int LAT_M0 = 5,
    parameter int LAT_M1 = 2,
    parameter int LAT_M2 = 5,
    parameter int LAT_M3 = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [2*NREQ-1:0]        req_mode,
    input  logic [IW*NREQ-1:0]       req_data,
    output logic [IW-1:0]            tree_ins,
    output logic                     tree_stb,
    output logic [1:0]               tree_mode,
    input  logic [4*DW-1:0]          tree_outputs,
    input  logic [3:0]               tree_out_stbs,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [4*DW-1:0]          rsp_data,
    output logic                     err
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);

    function automatic int lat_of(input logic [1:0] m);
        case (m)
            2'd0:    return LAT_M0;
            2'd1:    return LAT_M1;
            2'd2:    return LAT_M2;
            default: return LAT_M3;
        endcase
    endfunction

    function automatic int max_lat();
        int r;
        r = LAT_M0;
        if (LAT_M1 > r) r = LAT_M1;
        if (LAT_M2 > r) r = LAT_M2;
        if (LAT_M3 > r) r = LAT_M3;
        return r;
    endfunction

    localparam int MAXLAT = max_lat();
    localparam int QW     = $clog2(MAXLAT + 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_SWITCH = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [1:0]     pend_mode;
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           any_v;
    logic [1:0]     win_mode;
    logic [IW-1:0]  win_data;
    logic           mode_ok;
    logic           hs;
    logic           any_stb;
    logic           pop;
    logic           wd_fire;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [IDW-1:0] id_mem [DEPTH];
    logic [QW-1:0]  quiet;

    // Round-robin pick: first valid requester at or after rr_ptr.
    always_comb begin
        win   = '0;
        any_v = 1'b0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[idx]) begin
                any_v = 1'b1;
                win   = idx;
            end
        end
    end

    // Select the winner's mode and operands.
    always_comb begin
        win_mode = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_mode = req_mode[2*i +: 2];
                win_data = req_data[IW*i +: IW];
            end
        end
    end

    assign mode_ok   = (win_mode == tree_mode);
    assign hs        = (state == S_ISSUE) && any_v && mode_ok && (count != CW'(DEPTH)) && !rst;
    assign req_ready = hs ? (NREQ'(1) << win) : '0;
    assign any_stb   = |tree_out_stbs;
    assign pop       = any_stb && (count != '0);

    // Occupancy after this cycle's push/pop.
    always_comb begin
        case ({hs, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

`ifdef MUL_TREE_SCHED_WDOG_EN
    localparam int WDW = $clog2(MAXLAT + 6);
    logic [WDW-1:0] wd_cnt;

    assign wd_fire = (count != '0) && !any_stb && (wd_cnt >= WDW'(lat_of(tree_mode) + 4));

    // Watchdog: cycles spent waiting on an outstanding tree result.
    always_ff @(posedge clk) begin
        if (rst || count == '0 || any_stb || wd_fire) wd_cnt <= '0;
        else                                         wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign wd_fire = 1'b0;
`endif

    // ID FIFO pointers and occupancy; a watchdog trip flushes it.
    always_ff @(posedge clk) begin
        if (rst || wd_fire) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (hs)  wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count_nxt;
        end
    end

    // ID FIFO storage.
    always_ff @(posedge clk) begin
        if (hs) id_mem[wr_ptr] <= win;
    end

    // Scheduler FSM, round-robin pointer and mode serialisation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            tree_mode <= 2'b00;
            pend_mode <= 2'b00;
        end else if (wd_fire) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_v) begin
                        if (mode_ok) begin
                            state <= S_ISSUE;
                        end else begin
                            pend_mode <= win_mode;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!any_v) begin
                        state <= S_IDLE;
                    end else if (!mode_ok) begin
                        pend_mode <= win_mode;
                        state     <= S_DRAIN;
                    end else if (hs) begin
                        rr_ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (count_nxt == '0) begin
                        tree_mode <= pend_mode;
                        state     <= S_SWITCH;
                    end
                end
                default: state <= S_ISSUE;
            endcase
        end
    end

    // ---- issue stage: handshake registers operands and strobe ----
    always_ff @(posedge clk) begin
        if (rst) begin
            tree_stb <= 1'b0;
            tree_ins <= '0;
        end else begin
            tree_stb <= hs;
            if (hs) tree_ins <= win_data;
        end
    end

    // ---- result stage: tag tree output with FIFO head, flag stray strobes ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            err       <= 1'b0;
            quiet     <= QW'(MAXLAT);
        end else begin
            rsp_valid <= pop;
            if (pop) begin
                rsp_id   <= id_mem[rd_ptr];
                rsp_data <= tree_outputs;
            end
            // Results of operations flushed by reset may still arrive for a
            // while; those are dropped silently.
            if ((any_stb && count == '0 && quiet == '0) || wd_fire) err <= 1'b1;
            if (quiet != '0) quiet <= quiet - 1'b1;
        end
    end
endmodule

// File: tb/tb_mul_tree_sched.sv
// Self-checking bench for mul_tree_sched: stub multiplier tree, behavioural
// scheduler model, per-cycle comparison and directed literal checks.
// Watchdog scenarios run when MUL_TREE_SCHED_WDOG_EN is defined.
module tb_mul_tree_sched;
    localparam int DW = 16, NREQ = 4, IW = 128, DEPTH = 16;
    localparam int MAXLAT = 8;
    localparam logic [63:0] XK = 64'h0123_4567_89AB_CDEF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_mode = '0;
    logic [IW*NREQ-1:0] req_data = '0;
    logic [IW-1:0]     tree_ins;
    logic              tree_stb;
    logic [1:0]        tree_mode;
    logic [4*DW-1:0]   tree_outputs = '0;
    logic [3:0]        tree_out_stbs = '0;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [4*DW-1:0]   rsp_data;
    logic              err;

    mul_tree_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_data(req_data), .tree_ins(tree_ins),
        .tree_stb(tree_stb), .tree_mode(tree_mode), .tree_outputs(tree_outputs),
        .tree_out_stbs(tree_out_stbs), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_vec++;
        n_fail++;
        $display("FAIL %s: wait budget expired @cyc %0d", nm, cyc);
    endtask

    function automatic int lat_of(input int m);
        case (m)
            0: return 5;
            1: return 2;
            2: return 5;
            default: return 8;
        endcase
    endfunction

    // Stub tree: fixed per-mode latency, output = low operand bits ^ XK.
    typedef struct { int due; logic [63:0] d; } item_t;
    item_t sq[$];
    bit stub_hold = 0;
    bit inject = 0;

    always @(posedge clk) begin
        #2;
        if (inject) begin
            tree_out_stbs = 4'b0100;
            tree_outputs  = 64'hDEAD_BEEF_0BAD_F00D;
        end else if (!stub_hold && sq.size() > 0 && sq[0].due <= cyc) begin
            tree_out_stbs = 4'hF;
            tree_outputs  = sq[0].d;
            void'(sq.pop_front());
        end else begin
            tree_out_stbs = 4'h0;
        end
    end

    // Behavioural model state.
    int m_state = 0;            // 0 idle, 1 issue, 2 drain, 3 switch
    int m_mode = 0, m_rr = 0, m_pend = 0, m_quiet = MAXLAT, m_wd = 0;
    bit m_err = 0;
    int m_fifo[$];
    bit e_stb = 0, e_rv = 0;
    logic [127:0] e_ins = '0;
    int e_id = 0;
    logic [63:0] e_data = '0;

    // Event logs for directed checks.
    int g_cyc[$], g_id[$], s_cyc[$], r_cyc[$], r_id[$], mc_cyc[$], mc_val[$];
    logic [63:0] r_data[$];
    int err_cyc = -1;
    int last_mode = 0;

    task automatic clear_logs();
        g_cyc.delete(); g_id.delete(); s_cyc.delete(); r_cyc.delete();
        r_id.delete(); r_data.delete(); mc_cyc.delete(); mc_val.delete();
        err_cyc = -1;
    endtask

    // Compare DUT against model every cycle, then advance the model.
    always @(negedge clk) begin
        int w, wm, head, sz;
        bit av, ok, stb, pp, fire;
        logic [NREQ-1:0] exp_ready;
        if (cyc >= 1) begin
            w = 0; av = 0;
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[(m_rr + k) % NREQ]) begin
                    av = 1;
                    w  = (m_rr + k) % NREQ;
                end
            end
            wm = int'(req_mode[2*w +: 2]);
            ok = (m_state == 1) && av && (wm == m_mode) && (m_fifo.size() < DEPTH) && !rst;
            exp_ready = ok ? NREQ'(1 << w) : '0;

            chk("req_ready", 128'(req_ready), 128'(exp_ready));
            chk("tree_stb", 128'(tree_stb), 128'(e_stb));
            chk("tree_ins", tree_ins, e_ins);
            chk("tree_mode", 128'(tree_mode), 128'(m_mode));
            chk("rsp_valid", 128'(rsp_valid), 128'(e_rv));
            chk("rsp_id", 128'(rsp_id), 128'(e_id));
            chk("rsp_data", 128'(rsp_data), 128'(e_data));
            chk("err", 128'(err), 128'(m_err));

            if (|(req_ready & req_valid)) begin
                g_cyc.push_back(cyc);
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_id.push_back(i);
            end
            if (tree_stb) begin
                s_cyc.push_back(cyc);
                sq.push_back('{cyc + lat_of(int'(tree_mode)), tree_ins[63:0] ^ XK});
            end
            if (rsp_valid) begin
                r_cyc.push_back(cyc); r_id.push_back(int'(rsp_id)); r_data.push_back(rsp_data);
            end
            if (int'(tree_mode) != last_mode) begin
                mc_cyc.push_back(cyc); mc_val.push_back(int'(tree_mode));
                last_mode = int'(tree_mode);
            end
            if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;

            if (rst) begin
                m_state = 0; m_mode = 0; m_rr = 0; m_pend = 0; m_quiet = MAXLAT;
                m_wd = 0; m_err = 0; m_fifo.delete();
                e_stb = 0; e_ins = '0; e_rv = 0; e_id = 0; e_data = '0;
            end else begin
                sz   = m_fifo.size();
                stb  = |tree_out_stbs;
                pp   = stb && sz > 0;
                head = pp ? m_fifo[0] : 0;
                fire = 0;
`ifdef MUL_TREE_SCHED_WDOG_EN
                if (sz > 0 && !stb) begin
                    if (m_wd + 1 > lat_of(m_mode) + 4) fire = 1;
                    m_wd = fire ? 0 : m_wd + 1;
                end else begin
                    m_wd = 0;
                end
`endif
                if ((stb && sz == 0 && m_quiet == 0) || fire) m_err = 1;
                if (m_quiet > 0) m_quiet--;
                e_rv = pp;
                if (pp) begin e_id = head; e_data = tree_outputs; end
                e_stb = ok;
                if (ok) e_ins = req_data[IW*w +: IW];
                if (pp) void'(m_fifo.pop_front());
                if (ok) m_fifo.push_back(w);
                if (fire) begin
                    m_fifo.delete();
                    m_state = 0;
                end else begin
                    case (m_state)
                        0: if (av) begin
                               if (wm == m_mode) m_state = 1;
                               else begin m_pend = wm; m_state = 2; end
                           end
                        1: if (!av) m_state = 0;
                           else if (wm != m_mode) begin m_pend = wm; m_state = 2; end
                           else if (ok) m_rr = (w + 1) % NREQ;
                        2: if (m_fifo.size() == 0) begin m_mode = m_pend; m_state = 3; end
                        default: m_state = 1;
                    endcase
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick(2);
        chk("rst_ready", 128'(req_ready), 128'(0));
        chk("rst_tree_stb", 128'(tree_stb), 128'(0));
        chk("rst_tree_mode", 128'(tree_mode), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        rst = 1'b0;
        tick(MAXLAT + 2);
    endtask

    task automatic wait_grants(input int n, input int budget, input string nm);
        int b = 0;
        while (g_cyc.size() < n && b < budget) begin tick(); b++; end
        if (g_cyc.size() < n) timeout_fail(nm);
    endtask

    task automatic wait_drain(input int budget);
        int b = 0;
        stub_hold = 0;
        while ((sq.size() > 0 || m_fifo.size() > 0) && b < budget) begin tick(); b++; end
        if (sq.size() > 0 || m_fifo.size() > 0) timeout_fail("drain");
        tick(3);
    endtask

    int gm;
    int rmode[NREQ];

    initial begin
        #800000;
        $display("FAIL global_timeout @cyc %0d", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        tick(1);
        do_reset();

        // Single request: req0, mode 0, eight 1.0 lanes.
        clear_logs();
        req_mode = '0;
        req_data[IW-1:0] = {8{16'h3F80}};
        req_valid = 4'b0001;
        gm = cyc;
        wait_grants(1, 10, "single_grant");
        req_valid = '0;
        tick(12);
        if (g_cyc.size() >= 1 && s_cyc.size() >= 1 && r_cyc.size() >= 1) begin
            chk("single_grant_lat", 128'(g_cyc[0] - gm), 128'(1));
            chk("single_stb_lat", 128'(s_cyc[0] - g_cyc[0]), 128'(1));
            chk("single_rsp_lat", 128'(r_cyc[0] - g_cyc[0]), 128'(7));
            chk("single_rsp_id", 128'(r_id[0]), 128'(0));
            chk("single_rsp_data", 128'(r_data[0]), 128'(64'h3EA3_7AE7_B62B_F26F));
        end else timeout_fail("single_events");
        chk("single_rsp_count", 128'(r_cyc.size()), 128'(1));

        // Round robin: all four valid, same mode.
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 4; j++) req_data[IW*i + 32*j +: 32] = $urandom;
        req_valid = 4'hF;
        wait_grants(8, 20, "rr_grants");
        req_valid = '0;
        wait_drain(60);
        if (g_id.size() == 8 && r_id.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("rr_grant_id", 128'(g_id[i]), 128'(i % 4));
                chk("rr_rsp_id", 128'(r_id[i]), 128'(i % 4));
            end
            chk("rr_back_to_back", 128'(g_cyc[7] - g_cyc[0]), 128'(7));
        end else timeout_fail("rr_counts");

        // Mode switch: req0 mode 0 x3, then req1 mode 3.
        clear_logs();
        req_mode = '0;
        req_valid = 4'b0001;
        wait_grants(3, 20, "ms_first");
        req_valid = 4'b0010;
        req_mode = 8'b0000_1100;
        wait_grants(4, 60, "ms_switch");
        req_valid = '0;
        wait_drain(60);
        if (g_cyc.size() >= 4 && r_cyc.size() >= 3 && mc_cyc.size() >= 1) begin
            chk("ms_grant_after_drain", 128'(g_cyc[3] - r_cyc[2]), 128'(1));
            chk("ms_mode_cycle", 128'(mc_cyc[0]), 128'(r_cyc[2]));
            chk("ms_mode_val", 128'(mc_val[0]), 128'(3));
            chk("ms_grant_id", 128'(g_id[3]), 128'(1));
        end else timeout_fail("ms_events");

`ifndef MUL_TREE_SCHED_WDOG_EN
        // FIFO full: tree withholds results.
        clear_logs();
        stub_hold = 1;
        req_mode = 8'hFF;
        req_valid = 4'b0100;
        wait_grants(16, 40, "full_fill");
        tick(10);
        chk("full_grants", 128'(g_cyc.size()), 128'(16));
        chk("full_ready_low", 128'(req_ready), 128'(0));
        stub_hold = 0;
        tick();
        stub_hold = 1;
        tick(10);
        chk("full_one_more", 128'(g_cyc.size()), 128'(17));
        req_valid = '0;
        wait_drain(200);
`endif

        // Unexpected strobe with nothing in flight.
        clear_logs();
        inject = 1;
        tick();
        inject = 0;
        tick(3);
        chk("unexp_err", 128'(err), 128'(1));
        tick(5);
        chk("unexp_err_sticky", 128'(err), 128'(1));
        chk("unexp_no_rsp", 128'(r_cyc.size()), 128'(0));

`ifdef MUL_TREE_SCHED_WDOG_EN
        // Watchdog: one mode-1 grant whose result never comes.
        do_reset();
        clear_logs();
        stub_hold = 1;
        req_mode = 8'h01;
        req_valid = 4'b0001;
        wait_grants(1, 20, "wd_grant");
        req_valid = '0;
        tick(20);
        if (g_cyc.size() >= 1 && err_cyc >= 0)
            chk("wd_err_cycle", 128'(err_cyc - g_cyc[0]), 128'(8));
        else timeout_fail("wd_err");
        sq.delete();
        stub_hold = 0;
        tick(3);
`endif

        // Randomised traffic with a mid-operation reset.
        do_reset();
        gm = 0;
        for (int i = 0; i < NREQ; i++) rmode[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) gm = $urandom_range(0, 3);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 15) == 0) rmode[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : gm;
                req_mode[2*i +: 2] = 2'(rmode[i]);
                for (int j = 0; j < 4; j++) req_data[IW*i + 32*j +: 32] = $urandom;
            end
            req_valid = NREQ'($urandom);
            stub_hold = ($urandom_range(0, 3) == 0);
            rst = (n == 1500 || n == 1501);
            inject = (n == 2600);
            tick();
        end
        rst = 0;
        inject = 0;
        req_valid = '0;
        wait_drain(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
